// File: rtl/mac_pe_db_pkg.sv
// Shared defaults for the weight-stationary MAC processing element.
package mac_pe_db_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ACC_WIDTH_DEF  = 32;
  localparam int unsigned PIPE_MULT_DEF  = 0;
  localparam int unsigned SATURATE_DEF   = 0;

endpackage : mac_pe_db_pkg

// File: rtl/npu_sat_add.sv
// Signed accumulate add with one guard bit, overflow detect and optional clamp.
module npu_sat_add
  import mac_pe_db_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int unsigned SATURATE  = SATURATE_DEF
) (
  input  logic [ACC_WIDTH-1:0] a_i,
  input  logic [ACC_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0] sum_c_o,
  output logic                 ovf_c_o
);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0] sum_ext;

  // Overflow is possible only when both operands share a sign, so b_i's sign picks the clamp rail.
  always_comb begin
    sum_ext = {a_i[ACC_WIDTH-1], a_i} + {b_i[ACC_WIDTH-1], b_i};
    ovf_c_o = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
    sum_c_o = sum_ext[ACC_WIDTH-1:0];
    if ((SATURATE != 0) && ovf_c_o) begin
      sum_c_o = b_i[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
    end
  end

endmodule : npu_sat_add

// File: rtl/mac_pe_db.sv
// Weight-stationary systolic PE with double-buffered weights and optional multiplier pipeline.
module mac_pe_db
  import mac_pe_db_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int unsigned PIPE_MULT  = PIPE_MULT_DEF,
  parameter int unsigned SATURATE   = SATURATE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_shift,
  input  logic [DATA_WIDTH-1:0] w_in,
  output logic [DATA_WIDTH-1:0] w_out,
  input  logic                  w_swap,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic                  x_valid_in,
  output logic [DATA_WIDTH-1:0] x_out,
  output logic                  x_valid_out,
  input  logic [ACC_WIDTH-1:0]  y_in,
  input  logic                  ovf_in,
  output logic [ACC_WIDTH-1:0]  y_out,
  output logic                  ovf_out,
  output logic                  y_valid_out
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] shadow_q, active_q;
  logic [DATA_WIDTH-1:0] x_q;
  logic                  x_valid_q;
  logic [ACC_WIDTH-1:0]  y_q;
  logic                  ovf_q;
  logic                  y_valid_q;

  logic signed [PROD_WIDTH-1:0] prod_c;
  logic [ACC_WIDTH-1:0]         prod_ext_c;
  logic [ACC_WIDTH-1:0]         add_y_c, add_p_c, sum_c;
  logic                         add_ovf_in_c, add_v_c, ovf_c;

  // Shadow/active weight pair: a swap commits the pre-shift shadow even when shifting in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (w_shift) shadow_q <= w_in;
      if (w_swap)  active_q <= shadow_q;
    end
  end

  // Activation forwarding to the right neighbour, one cycle of latency regardless of pipelining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      x_valid_q <= 1'b0;
    end else begin
      x_q       <= x_in;
      x_valid_q <= x_valid_in;
    end
  end

  // Full-precision signed product; cannot overflow, then sign-extended to the accumulator width.
  always_comb begin
    prod_c     = $signed(x_in) * $signed(active_q);
    prod_ext_c = ACC_WIDTH'(prod_c);
  end

  if (PIPE_MULT != 0) begin : g_pipe
    logic [ACC_WIDTH-1:0] p1_q, y1_q;
    logic                 ovf1_q, v1_q;

    // Stage 1 captures product and aligned partial sum; payload only moves on valid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p1_q   <= '0;
        y1_q   <= '0;
        ovf1_q <= 1'b0;
        v1_q   <= 1'b0;
      end else begin
        v1_q <= x_valid_in;
        if (x_valid_in) begin
          p1_q   <= prod_ext_c;
          y1_q   <= y_in;
          ovf1_q <= ovf_in;
        end
      end
    end

    assign add_y_c      = y1_q;
    assign add_p_c      = p1_q;
    assign add_ovf_in_c = ovf1_q;
    assign add_v_c      = v1_q;
  end else begin : g_nopipe
    assign add_y_c      = y_in;
    assign add_p_c      = prod_ext_c;
    assign add_ovf_in_c = ovf_in;
    assign add_v_c      = x_valid_in;
  end

  npu_sat_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .SATURATE  (SATURATE)
  ) u_add (
    .a_i     (add_y_c),
    .b_i     (add_p_c),
    .sum_c_o (sum_c),
    .ovf_c_o (ovf_c)
  );

  // Output stage: result and chained overflow hold while invalid, valid strobe tracks every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      ovf_q     <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      y_valid_q <= add_v_c;
      if (add_v_c) begin
        y_q   <= sum_c;
        ovf_q <= add_ovf_in_c | ovf_c;
      end
    end
  end

  assign w_out       = shadow_q;
  assign x_out       = x_q;
  assign x_valid_out = x_valid_q;
  assign y_out       = y_q;
  assign ovf_out     = ovf_q;
  assign y_valid_out = y_valid_q;

endmodule : mac_pe_db

// File: tb/tb_mac_pe_db.sv
// Bench for mac_pe_db: wrap/no-pipe and saturate/pipe instances plus a 4-PE weight column.
module tb_mac_pe_db;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 32;
  localparam longint AMAX = 64'sd2147483647;
  localparam longint AMIN = -64'sd2147483648;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          w_shift, w_swap, x_valid_in, ovf_in;
  logic [DW-1:0] w_in, x_in;
  logic [AW-1:0] y_in;

  logic [DW-1:0] a_w_out, a_x_out, b_w_out, b_x_out;
  logic          a_xv, a_ovf, a_yv, b_xv, b_ovf, b_yv;
  logic [AW-1:0] a_y, b_y;

  mac_pe_db #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .PIPE_MULT(0), .SATURATE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .w_shift(w_shift), .w_in(w_in), .w_out(a_w_out), .w_swap(w_swap),
    .x_in(x_in), .x_valid_in(x_valid_in), .x_out(a_x_out), .x_valid_out(a_xv),
    .y_in(y_in), .ovf_in(ovf_in), .y_out(a_y), .ovf_out(a_ovf), .y_valid_out(a_yv));

  mac_pe_db #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .PIPE_MULT(1), .SATURATE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .w_shift(w_shift), .w_in(w_in), .w_out(b_w_out), .w_swap(w_swap),
    .x_in(x_in), .x_valid_in(x_valid_in), .x_out(b_x_out), .x_valid_out(b_xv),
    .y_in(y_in), .ovf_in(ovf_in), .y_out(b_y), .ovf_out(b_ovf), .y_valid_out(b_yv));

  // Four-PE column sharing shift/swap; weights chain w_out -> w_in downward.
  logic          c_shift, c_swap, c_xv;
  logic [DW-1:0] c_x;
  logic [DW-1:0] c_w [0:4];
  logic [DW-1:0] c_xo [0:3];
  logic          c_xvo [0:3];
  logic [AW-1:0] c_y [0:3];
  logic          c_o [0:3];
  logic          c_yv [0:3];

  for (genvar g = 0; g < 4; g++) begin : g_col
    mac_pe_db #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .PIPE_MULT(0), .SATURATE(0)) u_pe (
      .clk(clk), .rst_n(rst_n), .w_shift(c_shift), .w_in(c_w[g]), .w_out(c_w[g+1]), .w_swap(c_swap),
      .x_in(c_x), .x_valid_in(c_xv), .x_out(c_xo[g]), .x_valid_out(c_xvo[g]),
      .y_in('0), .ovf_in(1'b0), .y_out(c_y[g]), .ovf_out(c_o[g]), .y_valid_out(c_yv[g]));
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: signed arithmetic on wide integers, range-checked for overflow.
  logic [DW-1:0] m_shadow, m_active, m_x;
  logic          m_xv;
  logic [AW-1:0] ma_y, mb_y, pb_y;
  bit            ma_o, ma_v, mb_o, mb_v, pb_o, pb_v;

  function automatic void mac(input logic [DW-1:0] x, input logic [DW-1:0] w, input logic [AW-1:0] y,
                              input bit sat, output logic [AW-1:0] r, output bit o);
    longint s;
    s = longint'($signed(y)) + longint'($signed(x)) * longint'($signed(w));
    o = (s > AMAX) || (s < AMIN);
    if (sat && o) r = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    else          r = s[31:0];
  endfunction

  task automatic model_reset();
    m_shadow = '0; m_active = '0; m_x = '0; m_xv = 1'b0;
    ma_y = '0; ma_o = 0; ma_v = 0;
    mb_y = '0; mb_o = 0; mb_v = 0;
    pb_y = '0; pb_o = 0; pb_v = 0;
  endtask

  task automatic check_all();
    chk("a_y", a_y, ma_y);          chk("a_ovf", a_ovf, ma_o);   chk("a_yv", a_yv, ma_v);
    chk("a_x", a_x_out, m_x);       chk("a_xv", a_xv, m_xv);     chk("a_w", a_w_out, m_shadow);
    chk("b_y", b_y, mb_y);          chk("b_ovf", b_ovf, mb_o);   chk("b_yv", b_yv, mb_v);
    chk("b_x", b_x_out, m_x);       chk("b_xv", b_xv, m_xv);     chk("b_w", b_w_out, m_shadow);
  endtask

  // Advance the model by one edge using the current inputs, clock the DUTs, compare on the falling edge.
  task automatic cycle();
    logic [AW-1:0] ra, rb;
    bit oa, ob;
    mac(x_in, m_active, y_in, 1'b0, ra, oa);
    mac(x_in, m_active, y_in, 1'b1, rb, ob);
    mb_v = pb_v;
    if (pb_v) begin mb_y = pb_y; mb_o = pb_o; end
    pb_v = x_valid_in;
    if (x_valid_in) begin pb_y = rb; pb_o = ovf_in | ob; end
    ma_v = x_valid_in;
    if (x_valid_in) begin ma_y = ra; ma_o = ovf_in | oa; end
    m_x = x_in; m_xv = x_valid_in;
    if (w_swap)  m_active = m_shadow;
    if (w_shift) m_shadow = w_in;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    bit            sh;
    logic [DW-1:0] w;
    bit            sw;
    logic [DW-1:0] x;
    bit            xv;
    logic [AW-1:0] yin;
    bit            oi;
    logic [AW-1:0] ey;
    bit            eo;
    bit            ev;
  } vec_t;

  vec_t tbl [23];

  initial begin
    // Directed vectors; ey/eo/ev are the expected wrap/no-pipe outputs after the edge.
    tbl[0]  = '{1, 8'h05, 0, 8'h00, 0, 32'd0,        0, 32'd0,        0, 0};
    tbl[1]  = '{0, 8'h00, 1, 8'h00, 0, 32'd0,        0, 32'd0,        0, 0};
    tbl[2]  = '{0, 8'h00, 0, 8'h03, 1, 32'd10,       0, 32'd25,       0, 1};
    tbl[3]  = '{1, 8'hFE, 0, 8'h01, 1, 32'd0,        0, 32'd5,        0, 1};
    tbl[4]  = '{0, 8'h00, 0, 8'h02, 1, 32'd0,        0, 32'd10,       0, 1};
    tbl[5]  = '{0, 8'h00, 0, 8'h03, 1, 32'd0,        0, 32'd15,       0, 1};
    tbl[6]  = '{0, 8'h00, 1, 8'h04, 1, 32'd0,        0, 32'd20,       0, 1};
    tbl[7]  = '{0, 8'h00, 0, 8'h04, 1, 32'd0,        0, 32'hFFFFFFF8, 0, 1};
    tbl[8]  = '{1, 8'h03, 0, 8'h00, 0, 32'd0,        0, 32'hFFFFFFF8, 0, 0};
    tbl[9]  = '{0, 8'h00, 1, 8'h00, 0, 32'd0,        0, 32'hFFFFFFF8, 0, 0};
    tbl[10] = '{0, 8'h00, 0, 8'h02, 1, 32'd1,        0, 32'd7,        0, 1};
    tbl[11] = '{0, 8'h00, 0, 8'h02, 0, 32'd5,        1, 32'd7,        0, 0};
    tbl[12] = '{0, 8'h00, 0, 8'h02, 0, 32'd5,        1, 32'd7,        0, 0};
    tbl[13] = '{0, 8'h00, 0, 8'h02, 1, 32'd1,        1, 32'd7,        1, 1};
    tbl[14] = '{0, 8'h00, 0, 8'h00, 0, 32'd0,        0, 32'd7,        1, 0};
    tbl[15] = '{1, 8'h7F, 0, 8'h00, 0, 32'd0,        0, 32'd7,        1, 0};
    tbl[16] = '{0, 8'h00, 1, 8'h00, 0, 32'd0,        0, 32'd7,        1, 0};
    tbl[17] = '{0, 8'h00, 0, 8'h7F, 1, 32'h7FFFFF00, 0, 32'h80003E01, 1, 1};
    tbl[18] = '{1, 8'h80, 0, 8'h00, 0, 32'd0,        0, 32'h80003E01, 1, 0};
    tbl[19] = '{0, 8'h00, 1, 8'h00, 0, 32'd0,        0, 32'h80003E01, 1, 0};
    tbl[20] = '{0, 8'h00, 0, 8'h80, 1, 32'd0,        0, 32'h00004000, 0, 1};
    tbl[21] = '{0, 8'h00, 0, 8'h80, 1, 32'h80000000, 0, 32'h80004000, 0, 1};
    tbl[22] = '{0, 8'h00, 0, 8'h7F, 1, 32'h80000000, 0, 32'h7FFFC080, 1, 1};

    rst_n = 1'b0;
    w_shift = 0; w_swap = 0; w_in = '0; x_in = '0; x_valid_in = 0; y_in = '0; ovf_in = 0;
    c_shift = 0; c_swap = 0; c_x = '0; c_xv = 0; c_w[0] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // Directed table.
    for (int i = 0; i < 23; i++) begin
      w_shift = tbl[i].sh; w_in = tbl[i].w; w_swap = tbl[i].sw;
      x_in = tbl[i].x; x_valid_in = tbl[i].xv; y_in = tbl[i].yin; ovf_in = tbl[i].oi;
      cycle();
      chk($sformatf("tbl%0d_y", i), a_y, tbl[i].ey);
      chk($sformatf("tbl%0d_ovf", i), a_ovf, tbl[i].eo);
      chk($sformatf("tbl%0d_yv", i), a_yv, tbl[i].ev);
    end
    x_valid_in = 0;
    cycle();
    chk("sat_pipe_y", b_y, 32'h80000000);
    chk("sat_pipe_ovf", b_ovf, 1);

    // Randomized traffic with weights shifting/swapping under load.
    for (int i = 0; i < 400; i++) begin
      w_shift = ($urandom_range(0, 9) < 3);
      w_swap  = ($urandom_range(0, 9) < 2);
      w_in    = DW'($urandom);
      x_in    = DW'($urandom);
      x_valid_in = ($urandom_range(0, 9) < 7);
      ovf_in  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0:       y_in = $urandom;
        1:       y_in = {16'h7FFF, 16'($urandom)};
        default: y_in = {16'h8000, 16'($urandom)};
      endcase
      cycle();
    end

    // Asynchronous reset mid-operation with every input active.
    w_shift = 1; w_in = 8'h07; w_swap = 1; x_in = 8'h09; x_valid_in = 1; y_in = 32'd100; ovf_in = 1;
    c_shift = 1; c_w[0] = 8'h0B; c_swap = 1; c_x = 8'h05; c_xv = 1;
    cycle();
    cycle();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_a_y", a_y, 0);   chk("rst_a_ovf", a_ovf, 0); chk("rst_a_yv", a_yv, 0);
    chk("rst_a_x", a_x_out, 0); chk("rst_a_xv", a_xv, 0); chk("rst_a_w", a_w_out, 0);
    chk("rst_b_y", b_y, 0);   chk("rst_b_ovf", b_ovf, 0); chk("rst_b_yv", b_yv, 0);
    chk("rst_b_x", b_x_out, 0); chk("rst_b_xv", b_xv, 0); chk("rst_b_w", b_w_out, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_col%0d_w", i), c_w[i+1], 0);
    @(negedge clk);
    w_shift = 0; w_swap = 0; x_valid_in = 0; ovf_in = 0;
    c_shift = 0; c_swap = 0; c_xv = 0;
    rst_n = 1'b1;
    cycle();
    cycle();

    // Column weight load: bottom row's weight first, then commit.
    for (int k = 4; k >= 1; k--) begin
      c_w[0] = DW'(k); c_shift = 1;
      @(posedge clk); @(negedge clk);
    end
    c_shift = 0;
    for (int i = 0; i < 4; i++) chk($sformatf("col%0d_wout", i), c_w[i+1], 64'(i + 1));
    c_swap = 1;
    @(posedge clk); @(negedge clk);
    c_swap = 0; c_x = 8'd1; c_xv = 1;
    @(posedge clk); @(negedge clk);
    c_xv = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("col%0d_active", i), c_y[i], 64'(i + 1));
      chk($sformatf("col%0d_yv", i), c_yv[i], 1);
      chk($sformatf("col%0d_wout_hold", i), c_w[i+1], 64'(i + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_mac_pe_db
